regbus_master: RTL and testbench

Initiator for the 4-bit register bus served by the resolution register file and its sibling register files. It accepts one command at a time from an upstream command source, such as the UART command decoder. It drives `address`/`data`/`valid` onto the bus, waits for the responder's one-cycle `ack` and captures any read-back data. It then returns a single-cycle response upstream, reporting a timeout error when no responder answers.

---
 rtl/regbus_master.sv | 165 ++++++++++++++++
 tb/tb_regbus_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_master.sv
// regbus_master: single-outstanding initiator for the 4-bit register bus.
// Takes one command from an upstream source, issues it to the responders,
// waits for the one-cycle ack and returns a single-cycle response.
// A command whose data is 4'b1111 is a read query; anything else is a write.
//
// Build option: define REGBUS_TIMEOUT_EN to include the REQ timeout counter.
// Without it the master waits in REQ indefinitely and TIMEOUT is only
// range-checked.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a command (cmd_ready high)
// REQ   | request on the bus, waiting for bus_ack (or for the timeout)
// GAP   | one cycle with bus_valid low for the responder's turnaround

module regbus_master #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cmd_addr,
    input  logic [3:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [3:0] bus_address,
    output logic [3:0] bus_data,
    output logic       bus_valid,
    input  logic       bus_ack,
    input  logic [3:0] bus_rdata,
    input  logic       bus_rdata_valid,
    output logic [3:0] rsp_data,
    output logic       rsp_error,
    output logic       rsp_valid
);

    localparam logic [3:0] RD_QUERY = 4'b1111;

    // The timeout counter is 8 bits, so TIMEOUT must fit in 1..255.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("regbus_master: TIMEOUT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] bus_address_n;
    logic [3:0] bus_data_n;
    logic       bus_valid_n;
    logic [3:0] rsp_data_n;
    logic       rsp_error_n;
    logic       rsp_valid_n;

`ifdef REGBUS_TIMEOUT_EN
    // Last counter value before the request is abandoned: the error shows
    // up after the TIMEOUT-th edge in REQ, so bus_valid is high TIMEOUT cycles.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] to_cnt, to_cnt_n;
`endif

    assign cmd_ready = (state == IDLE);

    // Register the state and every bus/response output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bus_address <= 4'd0;
            bus_data    <= 4'd0;
            bus_valid   <= 1'b0;
            rsp_data    <= 4'd0;
            rsp_error   <= 1'b0;
            rsp_valid   <= 1'b0;
`ifdef REGBUS_TIMEOUT_EN
            to_cnt      <= 8'd0;
`endif
        end else begin
            state       <= state_n;
            bus_address <= bus_address_n;
            bus_data    <= bus_data_n;
            bus_valid   <= bus_valid_n;
            rsp_data    <= rsp_data_n;
            rsp_error   <= rsp_error_n;
            rsp_valid   <= rsp_valid_n;
`ifdef REGBUS_TIMEOUT_EN
            to_cnt      <= to_cnt_n;
`endif
        end
    end

    // Next state and next register values; rsp_valid defaults low so it is
    // a single-cycle strobe, everything else holds unless changed below.
    always_comb begin
        state_n       = state;
        bus_address_n = bus_address;
        bus_data_n    = bus_data;
        bus_valid_n   = bus_valid;
        rsp_data_n    = rsp_data;
        rsp_error_n   = rsp_error;
        rsp_valid_n   = 1'b0;
`ifdef REGBUS_TIMEOUT_EN
        to_cnt_n      = to_cnt;
`endif

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    bus_address_n = cmd_addr;
                    bus_data_n    = cmd_data;
                    bus_valid_n   = 1'b1;
`ifdef REGBUS_TIMEOUT_EN
                    to_cnt_n      = 8'd0;
`endif
                    state_n       = REQ;
                end
            end

            REQ: begin
                if (bus_ack) begin
                    // An ack always wins, even on the edge the timeout would fire.
                    bus_valid_n = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = GAP;
                    if (bus_data == RD_QUERY) begin
                        if (bus_rdata_valid) begin
                            rsp_data_n  = bus_rdata;
                            rsp_error_n = 1'b0;
                        end else begin
                            rsp_data_n  = 4'd0;
                            rsp_error_n = 1'b1;
                        end
                    end else begin
                        rsp_data_n  = bus_data;
                        rsp_error_n = 1'b0;
                    end
                end
`ifdef REGBUS_TIMEOUT_EN
                else begin
                    to_cnt_n = to_cnt + 8'd1;
                    if (to_cnt == TO_LAST) begin
                        bus_valid_n = 1'b0;
                        rsp_valid_n = 1'b1;
                        rsp_error_n = 1'b1;
                        rsp_data_n  = 4'd0;
                        state_n     = GAP;
                    end
                end
`endif
            end

            GAP: begin
                state_n = IDLE;
            end

            default: begin
                state_n     = IDLE;
                bus_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_regbus_master.sv
// Bench for regbus_master: directed and random commands against a
// reference model that predicts response edge, payload and error from the
// command, the responder's ack delay and the timeout rule.

module tb_regbus_master;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cmd_addr;
    logic [3:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] bus_address;
    logic [3:0] bus_data;
    logic       bus_valid;
    logic       bus_ack;
    logic [3:0] bus_rdata;
    logic       bus_rdata_valid;
    logic [3:0] rsp_data;
    logic       rsp_error;
    logic       rsp_valid;

    int total = 0;
    int bad   = 0;

    regbus_master #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .bus_address    (bus_address),
        .bus_data       (bus_data),
        .bus_valid      (bus_valid),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata),
        .bus_rdata_valid(bus_rdata_valid),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .rsp_valid      (rsp_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue one command and play the responder. Ack is driven after the
    // (1+d)-th edge following acceptance, so it is sampled on edge 2+d.
    // Entered and left at a negedge. stray adds acks in GAP/IDLE that must
    // be ignored; hold keeps cmd_valid high for back-to-back traffic.
    task automatic run_cmd(input logic [3:0] a, input logic [3:0] dt,
                           input int d, input bit rdv, input logic [3:0] rd,
                           input bit hold, input bit stray,
                           output longint e0_t);
        int         wait_n = 0;
        int         resp_k = -1;
        int         bv_cnt = 0;
        int         spur   = 0;
        int         exp_k;
        bit         exp_to;
        logic [3:0] exp_data;
        bit         exp_err;
        logic [3:0] got_data = 4'd0;
        bit         got_err  = 1'b0;
        bit         done     = 1'b0;

        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("ready_before_cmd", int'(cmd_ready), 1);
        cmd_addr  = a;
        cmd_data  = dt;
        cmd_valid = 1'b1;
        @(posedge clk);
        e0_t = $time;

        // reference model
`ifdef REGBUS_TIMEOUT_EN
        exp_to = (TO < 2 + d);
`else
        exp_to = 1'b0;
`endif
        exp_k = exp_to ? TO : 2 + d;
        if (exp_to) begin
            exp_data = 4'd0;
            exp_err  = 1'b1;
        end else if (dt == 4'hF) begin
            exp_data = rdv ? rd : 4'd0;
            exp_err  = !rdv;
        end else begin
            exp_data = dt;
            exp_err  = 1'b0;
        end

        for (int k = 0; k < exp_k + 6 && !done; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("bus_address", int'(bus_address), int'(a));
                check("bus_data", int'(bus_data), int'(dt));
                if (!hold) cmd_valid = 1'b0;
            end
            if (resp_k < 0) begin
                if (bus_valid) bv_cnt++;
                if (rsp_valid) begin
                    resp_k   = k;
                    got_data = rsp_data;
                    got_err  = rsp_error;
                    check("ready_low_in_gap", int'(cmd_ready), 0);
                end
            end else begin
                if (rsp_valid) spur++;
                if (bus_valid) spur++;
                if (k == resp_k + 1) begin
                    check("ready_after_gap", int'(cmd_ready), 1);
                    check("rsp_data_hold", int'(rsp_data), int'(exp_data));
                    check("bus_address_hold", int'(bus_address), int'(a));
                    done = 1'b1;
                end
            end
            bus_ack         = (k == 1 + d) || (stray && resp_k >= 0);
            bus_rdata_valid = (k == 1 + d) && rdv;
            bus_rdata       = (k == 1 + d) ? rd : 4'($urandom);
        end

        check("resp_edge", resp_k, exp_k);
        check("bus_valid_cycles", bv_cnt, exp_k);
        check("rsp_data", int'(got_data), int'(exp_data));
        check("rsp_error", int'(got_err), int'(exp_err));
        check("no_spurious", spur, 0);
    endtask

    longint     t0, t1, t2;
    logic [3:0] ra, rdt, rrd;
    int         viol;

    initial begin
        rst             = 1'b1;
        cmd_addr        = 4'd0;
        cmd_data        = 4'd0;
        cmd_valid       = 1'b0;
        bus_ack         = 1'b0;
        bus_rdata       = 4'd0;
        bus_rdata_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_bus_valid", int'(bus_valid), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_data", int'(rsp_data), 0);
        check("rst_rsp_error", int'(rsp_error), 0);
        check("rst_bus_address", int'(bus_address), 0);
        check("rst_bus_data", int'(bus_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // directed: write, read, read without read data
        run_cmd(4'hD, 4'h3, 0, 1'b0, 4'h0, 1'b0, 1'b0, t0);
        run_cmd(4'hD, 4'hF, 0, 1'b1, 4'h3, 1'b0, 1'b0, t0);
        run_cmd(4'h6, 4'hF, 0, 1'b0, 4'h9, 1'b0, 1'b1, t0);
`ifdef REGBUS_TIMEOUT_EN
        run_cmd(4'h2, 4'h5, 1000, 1'b0, 4'h0, 1'b0, 1'b0, t0);
        run_cmd(4'h3, 4'h1, TO - 2, 1'b0, 4'h0, 1'b0, 1'b0, t0);
        run_cmd(4'h4, 4'hF, TO - 1, 1'b1, 4'h7, 1'b0, 1'b0, t0);
`else
        run_cmd(4'h2, 4'h5, 100, 1'b0, 4'h0, 1'b0, 1'b0, t0);
`endif

        // back-to-back with cmd_valid held high
        run_cmd(4'h1, 4'hA, 0, 1'b0, 4'h0, 1'b1, 1'b0, t0);
        run_cmd(4'h7, 4'hF, 0, 1'b1, 4'hC, 1'b1, 1'b0, t1);
        run_cmd(4'h9, 4'h2, 0, 1'b0, 4'h0, 1'b1, 1'b0, t2);
        cmd_valid = 1'b0;
        check("b2b_spacing_1", int'((t1 - t0) / 10), 4);
        check("b2b_spacing_2", int'((t2 - t1) / 10), 4);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            ra  = 4'($urandom);
            rdt = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            rrd = 4'($urandom);
            run_cmd(ra, rdt, int'($urandom_range(0, 20)), 1'($urandom),
                    rrd, 1'b0, 1'($urandom), t0);
        end

        // reset while a request is outstanding
        bus_ack         = 1'b0;
        bus_rdata_valid = 1'b0;
        @(negedge clk);
        cmd_addr  = 4'hB;
        cmd_data  = 4'h4;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_bus_valid", int'(bus_valid), 1);
        rst = 1'b1;
        #1;
        check("async_rst_bus_valid", int'(bus_valid), 0);
        check("async_rst_rsp_valid", int'(rsp_valid), 0);
        check("async_rst_cmd_ready", int'(cmd_ready), 1);
        check("async_rst_bus_address", int'(bus_address), 0);
        @(negedge clk);
        rst  = 1'b0;
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid || bus_valid || !cmd_ready) viol++;
        end
        check("post_rst_quiet", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
